// File: rtl/muldiv_arbiter_if.sv
// Bus bundle between the hart-facing request/response ports, the shared
// mul/div unit and the arbiter that sits between them.
//   req_*        : per-hart request side (packed, hart h in slice h)
//   muldiv_*     : command/result side of the shared mul/div unit
//   resp_*       : per-hart response side
//   err_sticky   : latched protocol error flag
// Modport master is used by the arbiter, slave by whatever surrounds it.
interface muldiv_arbiter_if #(
  parameter int NUM_HARTS = 2,
  parameter int HART_ID_W = 1,
  parameter int XLEN      = 32
);
  logic [NUM_HARTS-1:0]      req_valid;
  logic [NUM_HARTS-1:0]      req_ready;
  logic [3*NUM_HARTS-1:0]    req_op;
  logic [XLEN*NUM_HARTS-1:0] req_a;
  logic [XLEN*NUM_HARTS-1:0] req_b;
  logic [5*NUM_HARTS-1:0]    req_rd;

  logic                      muldiv_start;
  logic [2:0]                muldiv_op;
  logic [XLEN-1:0]           muldiv_a;
  logic [XLEN-1:0]           muldiv_b;
  logic [HART_ID_W-1:0]      muldiv_hart_id;
  logic [4:0]                muldiv_rd;
  logic                      muldiv_busy;
  logic                      muldiv_done;
  logic [XLEN-1:0]           muldiv_result;
  logic [HART_ID_W-1:0]      muldiv_done_hart_id;

  logic [NUM_HARTS-1:0]      resp_valid;
  logic [XLEN-1:0]           resp_data;
  logic [4:0]                resp_rd;
  logic                      resp_err;
  logic                      err_sticky;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_rd,
    input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id,
    output req_ready,
    output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
    output resp_valid, resp_data, resp_rd, resp_err, err_sticky
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_rd,
    output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id,
    input  req_ready,
    input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
    input  resp_valid, resp_data, resp_rd, resp_err, err_sticky
  );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one mul/div unit among NUM_HARTS harts.
// One operation is in flight at a time: IDLE grants a hart (req_ready is
// combinational in the grant cycle), START pulses muldiv_start, WAIT waits
// for muldiv_done or a TIMEOUT, RESP returns a one-cycle per-hart response.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_arbiter_if.master (request, unit and response signals)
module muldiv_arbiter #(
  parameter int NUM_HARTS = 2,
  parameter int HART_ID_W = 1,
  parameter int XLEN      = 32,
  parameter int TIMEOUT   = 64
) (
  input logic              clk,
  input logic              rst,
  muldiv_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t               state;
  logic [HART_ID_W-1:0] rr_ptr;
  logic [CNT_W-1:0]     wait_cnt;

  logic [2:0]      op_arr [NUM_HARTS];
  logic [XLEN-1:0] a_arr  [NUM_HARTS];
  logic [XLEN-1:0] b_arr  [NUM_HARTS];
  logic [4:0]      rd_arr [NUM_HARTS];

  logic                 grant_any;
  logic [HART_ID_W-1:0] grant_id;
  logic                 can_grant;

  // Hart index reached by stepping ofs places past ptr, wrapping at NUM_HARTS.
  function automatic logic [HART_ID_W-1:0] rr_cand(input logic [HART_ID_W-1:0] ptr,
                                                   input int ofs);
    int sum;
    sum = int'(ptr) + ofs;
    if (sum >= NUM_HARTS) sum = sum - NUM_HARTS;
    return HART_ID_W'(sum);
  endfunction

  function automatic logic [NUM_HARTS-1:0] hart_onehot(input logic [HART_ID_W-1:0] id);
    logic [NUM_HARTS-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_unpack
    assign op_arr[g] = bus.req_op[3*g +: 3];
    assign a_arr[g]  = bus.req_a[XLEN*g +: XLEN];
    assign b_arr[g]  = bus.req_b[XLEN*g +: XLEN];
    assign rd_arr[g] = bus.req_rd[5*g +: 5];
  end

  // First valid requester at or after rr_ptr wins.
  always_comb begin
    logic [HART_ID_W-1:0] cand;
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      cand = rr_cand(rr_ptr, i);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // rst gates the grant so req_ready stays low throughout reset even
  // though the FSM already sits in IDLE.
  assign can_grant     = !rst && (state == IDLE) && !bus.muldiv_busy && grant_any;
  assign bus.req_ready = can_grant ? hart_onehot(grant_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      wait_cnt           <= '0;
      bus.muldiv_start   <= 1'b0;
      bus.muldiv_op      <= '0;
      bus.muldiv_a       <= '0;
      bus.muldiv_b       <= '0;
      bus.muldiv_hart_id <= '0;
      bus.muldiv_rd      <= '0;
      bus.resp_valid     <= '0;
      bus.resp_data      <= '0;
      bus.resp_rd        <= '0;
      bus.resp_err       <= 1'b0;
      bus.err_sticky     <= 1'b0;
    end else begin
      bus.muldiv_start <= 1'b0;
      bus.resp_valid   <= '0;

      // A done outside WAIT has no operation to belong to.
      if (bus.muldiv_done && state != WAIT) bus.err_sticky <= 1'b1;

      case (state)
        IDLE: begin
          if (can_grant) begin
            bus.muldiv_op      <= op_arr[grant_id];
            bus.muldiv_a       <= a_arr[grant_id];
            bus.muldiv_b       <= b_arr[grant_id];
            bus.muldiv_rd      <= rd_arr[grant_id];
            bus.muldiv_hart_id <= grant_id;
            bus.muldiv_start   <= 1'b1;
            state              <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.muldiv_done) begin
            // A mismatched tag is flagged but the response still goes to
            // the hart that owns the in-flight operation.
            if (bus.muldiv_done_hart_id != bus.muldiv_hart_id) bus.err_sticky <= 1'b1;
            bus.resp_data  <= bus.muldiv_result;
            bus.resp_rd    <= bus.muldiv_rd;
            bus.resp_valid <= hart_onehot(bus.muldiv_hart_id);
            state          <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.resp_data  <= '0;
            bus.resp_rd    <= bus.muldiv_rd;
            bus.resp_err   <= 1'b1;
            bus.err_sticky <= 1'b1;
            bus.resp_valid <= hart_onehot(bus.muldiv_hart_id);
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          bus.resp_err <= 1'b0;
          if (bus.muldiv_hart_id == HART_ID_W'(NUM_HARTS - 1)) rr_ptr <= '0;
          else                                                 rr_ptr <= bus.muldiv_hart_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 Parameter NUM_HARTS, default 2, number of requesting harts.
REQ-002 Parameter HART_ID_W, default 1, hart index width, equal to clog2(NUM_HARTS), minimum 1.
REQ-003 Parameter XLEN, default 32, operand and result width.
REQ-004 Parameter TIMEOUT, default 64, number of WAIT cycles before an abort.
REQ-005 Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_HARTS  per-hart request.
- req_ready  out  NUM_HARTS  per-hart grant, one-hot or zero.
- req_op  in  3*NUM_HARTS  packed muldiv op, hart h at [3h+2:3h].
- req_a, req_b  in  XLEN*NUM_HARTS  packed operands.
- req_rd  in  5*NUM_HARTS  packed destination register.
- muldiv_start  out  1  one-cycle start pulse.
- muldiv_op  out  3  op to the unit.
- muldiv_a, muldiv_b  out  XLEN  operands to the unit.
- muldiv_hart_id  out  HART_ID_W  hart tag to the unit.
- muldiv_rd  out  5  rd tag to the unit.
- muldiv_busy  in  1  unit busy.
- muldiv_done  in  1  unit result valid.
- muldiv_result  in  XLEN  result from the unit.
- muldiv_done_hart_id  in  HART_ID_W  tag returned by the unit.
- resp_valid  out  NUM_HARTS  per-hart one-cycle response.
- resp_data  out  XLEN  response result.
- resp_rd  out  5  response destination register.
- resp_err  out  1  qualifies resp_valid; set on timeout.
- err_sticky  out  1  latched protocol error.

Function
REQ-006 FSM states: IDLE, START, WAIT, RESP.
- The arbiter SHALL hold one operation in flight at a time.
REQ-007 IDLE: when any req_valid is high and muldiv_busy=0, the arbiter SHALL grant one hart by round-robin.
- The search SHALL start at rr_ptr.
- req_ready[winner] SHALL be high combinationally in that same cycle.
- op, a, b, rd and the winner id SHALL be latched.
- The FSM SHALL then go to START.
REQ-008 In IDLE, if muldiv_busy=1 or no request is valid, req_ready SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-009 START: muldiv_start SHALL be 1 for exactly one cycle, with the latched op/a/b/rd/hart_id on the unit ports; the FSM SHALL then go to WAIT.
REQ-010 muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id and muldiv_rd SHALL hold their latched values from START until the next grant.
REQ-011 WAIT: on muldiv_done=1, the arbiter SHALL latch muldiv_result into resp_data and the latched rd into resp_rd, then go to RESP.
REQ-012 A WAIT cycle counter SHALL reset to 0 on entry to WAIT.
- On reaching TIMEOUT-1 without muldiv_done, the arbiter SHALL set resp_data=0 and resp_err=1, set err_sticky, and go to RESP.
REQ-013 RESP: resp_valid[granted hart] SHALL be 1 for exactly one cycle.
- rr_ptr SHALL become (granted+1) mod NUM_HARTS.
- The FSM SHALL return to IDLE.
- resp_err SHALL clear after RESP.
REQ-014 The grant-to-response latency SHALL be 3 + N cycles, where N is the number of WAIT cycles until done.
- A new grant SHALL be possible in the cycle after RESP.
REQ-015 If muldiv_done is high while the FSM is not in WAIT, the arbiter SHALL ignore it and set err_sticky.
REQ-016 If muldiv_done_hart_id differs from the latched hart id in WAIT, the arbiter SHALL set err_sticky.
- The response SHALL still go to the latched hart.
REQ-017 A hart dropping req_valid before it is granted SHALL be legal and SHALL cause no state change.
REQ-018 A requester that holds req_valid SHALL be granted within NUM_HARTS grants.
REQ-019 err_sticky SHALL clear only on rst.

Reset
REQ-020 While rst=1, the following SHALL hold asynchronously:
- FSM=IDLE, rr_ptr=0, counter=0.
- req_ready, resp_valid, muldiv_start and resp_err = 0.
- All data and tag outputs = 0.
- err_sticky = 0.
REQ-021 rst asserted mid-operation SHALL abandon the in-flight operation with no response.
- A muldiv_done arriving after rst deasserts SHALL be treated per REQ-015.

Verification
REQ-022 Hart0 requests MUL, a=6, b=7, rd=5; the unit returns done 4 cycles after start with result 42.
- Required: req_ready[0] in cycle 0, start in cycle 1, resp_valid[0] in cycle 6, resp_data=42, resp_rd=5.
REQ-023 Both harts request continuously after reset.
- Required: grant order 0,1,0,1; each hart's resp_rd matches its own rd.
REQ-024 muldiv_busy=1 while hart1 is requesting.
- Required: no req_ready; the grant occurs in the first cycle busy=0.
REQ-025 With TIMEOUT=8, the unit never asserts done.
- Required: resp_valid with resp_err=1 and resp_data=0 in the cycle after 8 WAIT cycles; err_sticky=1; the next request is serviced normally.
REQ-026 Two stray-done cases:
- Stray muldiv_done in IDLE: err_sticky=1, no resp_valid.
- done_hart_id=1 while hart0 is in flight: response goes to hart0, err_sticky=1.
REQ-027 rst pulsed during WAIT.
- Required: all outputs 0 immediately; no response for the aborted operation.
